// File: rtl/team_11_wb_master_arbiter.sv
// team_11 Wishbone master arbiter.
// Round-robin sharing of one classic single-beat Wishbone master port among
// NUM_REQ internal requesters, with a per-transfer timeout so that a silent
// upstream arbitrator cannot stall a requester forever.
module team_11_wb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   nrst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [32*NUM_REQ-1:0]  req_adr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  input  logic [4*NUM_REQ-1:0]   req_sel,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [31:0]            req_rdata,
  output logic [31:0]            ADR_O,
  output logic [31:0]            DAT_O,
  output logic [3:0]             SEL_O,
  output logic                   WE_O,
  output logic                   STB_O,
  output logic                   CYC_O,
  input  logic [31:0]            DAT_I,
  input  logic                   ACK_I,
  output logic                   busy,
  output logic [1:0]             grant_id
);

  localparam int               CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0]    CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e               state_q;
  logic [1:0]           last_grant_q;
  logic [1:0]           grant_id_q;
  logic [CW-1:0]        cnt_q;
  logic [31:0]          adr_q;
  logic [31:0]          dat_q;
  logic [3:0]           sel_q;
  logic                 we_q;
  logic                 stb_q;
  logic                 cyc_q;
  logic [31:0]          rdata_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   err_q;
  logic                 busy_q;

  // Requester fields re-packed into fixed 4-entry tables so a 2-bit index is always in range.
  logic [31:0] adr_a   [4];
  logic [31:0] wdata_a [4];
  logic [3:0]  sel_a   [4];
  logic [3:0]  we_a;
  logic [3:0]  valid_a;

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NUM_REQ) begin : g_real
      assign adr_a[g]   = req_adr[32*g +: 32];
      assign wdata_a[g] = req_wdata[32*g +: 32];
      assign sel_a[g]   = req_sel[4*g +: 4];
      assign we_a[g]    = req_we[g];
      assign valid_a[g] = req_valid[g];
    end else begin : g_pad
      assign adr_a[g]   = 32'h0000_0000;
      assign wdata_a[g] = 32'h0000_0000;
      assign sel_a[g]   = 4'b0000;
      assign we_a[g]    = 1'b0;
      assign valid_a[g] = 1'b0;
    end
  end

  // Round-robin pick: first valid requester after 'last', wrapping; returns {found, index}.
  function automatic logic [2:0] pick_winner(input logic [3:0] valid, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [2:0] sum;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last} + 3'(k);
      sum = (sum >= 3'(NUM_REQ)) ? (sum - 3'(NUM_REQ)) : sum;
      if (!found && valid[sum[1:0]]) begin
        found = 1'b1;
        idx   = sum[1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  logic [2:0] pick_s;
  logic       win_found_s;
  logic [1:0] win_idx_s;

  // Arbitration decision for the current cycle, consumed only in IDLE.
  always_comb begin
    pick_s      = pick_winner(valid_a, last_grant_q);
    win_found_s = pick_s[2];
    win_idx_s   = pick_s[1:0];
  end

  // Main transfer FSM; every output is a register written here.
  always_ff @(posedge wb_clk_i or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'(NUM_REQ - 1);
      grant_id_q   <= 2'd0;
      cnt_q        <= '0;
      adr_q        <= 32'h0000_0000;
      dat_q        <= 32'h0000_0000;
      sel_q        <= 4'b0000;
      we_q         <= 1'b0;
      stb_q        <= 1'b0;
      cyc_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      done_q       <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found_s) begin
            adr_q        <= adr_a[win_idx_s];
            dat_q        <= wdata_a[win_idx_s];
            sel_q        <= sel_a[win_idx_s];
            we_q         <= we_a[win_idx_s];
            stb_q        <= 1'b1;
            cyc_q        <= 1'b1;
            last_grant_q <= win_idx_s;
            grant_id_q   <= win_idx_s;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_BUS;
          end else begin
            state_q      <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (ACK_I) begin
            // ACK takes priority over a simultaneous timeout expiry.
            if (!we_q) begin
              rdata_q <= DAT_I;
            end else begin
              rdata_q <= rdata_q;
            end
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            done_q  <= NUM_REQ'(1'b1) << grant_id_q;
            err_q   <= '0;
            state_q <= ST_RESP;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            done_q  <= NUM_REQ'(1'b1) << grant_id_q;
            err_q   <= NUM_REQ'(1'b1) << grant_id_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          done_q  <= '0;
          err_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          adr_q   <= 32'h0000_0000;
          dat_q   <= 32'h0000_0000;
          sel_q   <= 4'b0000;
          we_q    <= 1'b0;
          stb_q   <= 1'b0;
          cyc_q   <= 1'b0;
          done_q  <= '0;
          err_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign SEL_O     = sel_q;
  assign WE_O      = we_q;
  assign STB_O     = stb_q;
  assign CYC_O     = cyc_q;
  assign req_rdata = rdata_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_team_11_wb_master_arbiter.sv
// Directed self-checking bench for team_11_wb_master_arbiter (3 requesters, timeout 8).
module tb_team_11_wb_master_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic            clk;
  logic            nrst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_we;
  logic [32*NR-1:0] req_adr;
  logic [32*NR-1:0] req_wdata;
  logic [4*NR-1:0] req_sel;
  logic [NR-1:0]   req_done;
  logic [NR-1:0]   req_err;
  logic [31:0]     req_rdata;
  logic [31:0]     ADR_O;
  logic [31:0]     DAT_O;
  logic [3:0]      SEL_O;
  logic            WE_O;
  logic            STB_O;
  logic            CYC_O;
  logic [31:0]     DAT_I;
  logic            ACK_I;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  team_11_wb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .nrst     (nrst),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_wdata(req_wdata),
    .req_sel  (req_sel),
    .req_done (req_done),
    .req_err  (req_err),
    .req_rdata(req_rdata),
    .ADR_O    (ADR_O),
    .DAT_O    (DAT_O),
    .SEL_O    (SEL_O),
    .WE_O     (WE_O),
    .STB_O    (STB_O),
    .CYC_O    (CYC_O),
    .DAT_I    (DAT_I),
    .ACK_I    (ACK_I),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    nrst = 1'b0; req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0;
    req_sel = '0; DAT_I = 32'h0; ACK_I = 1'b0;
    #1;
    checks++;
    if ({CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O} !== 71'd0) begin
      errors++; $display("FAIL reset_wb: got cyc=%b stb=%b adr=%h expected all 0", CYC_O, STB_O, ADR_O);
    end
    checks++;
    if ({req_done, req_err, busy, grant_id, req_rdata} !== 41'd0) begin
      errors++; $display("FAIL reset_status: got done=%b err=%b busy=%b gid=%0d rdata=%h expected 0", req_done, req_err, busy, grant_id, req_rdata);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cnt [NR];
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    req_valid = 3'b111; req_we = 3'b000;
    req_adr = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      checks++;
      if (grant_id !== 2'(t % NR) || STB_O !== 1'b1) begin
        errors++; $display("FAIL rr_grant[%0d]: got gid=%0d stb=%b expected gid=%0d stb=1", t, grant_id, STB_O, t % NR);
      end
      ACK_I = 1'b1; DAT_I = 32'h0;
      @(negedge clk);
      ACK_I = 1'b0;
      checks++;
      if (req_done !== (3'b001 << (t % NR))) begin
        errors++; $display("FAIL rr_done[%0d]: got %b expected %b", t, req_done, 3'b001 << (t % NR));
      end
      for (int i = 0; i < NR; i++) if (req_done[i]) cnt[i]++;
      @(negedge clk);
      if (t == 5) req_valid = 3'b000;
    end
    checks++;
    if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2) begin
      errors++; $display("FAIL rr_counts: got %0d,%0d,%0d expected 2,2,2", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  task automatic test_single_read();
    req_valid = 3'b001; req_we = 3'b000;
    req_adr[31:0] = 32'h3000_0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (STB_O !== 1'b1 || CYC_O !== 1'b1 || ADR_O !== 32'h3000_0010 || WE_O !== 1'b0 || req_done !== 3'b000) begin
        errors++; $display("FAIL read_bus[%0d]: got stb=%b adr=%h we=%b done=%b expected 1/30000010/0/000", c, STB_O, ADR_O, WE_O, req_done);
      end
      if (c == 2) begin
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk);
    ACK_I = 1'b0; DAT_I = 32'h0; req_valid = 3'b000;
    checks++;
    if (STB_O !== 1'b0 || CYC_O !== 1'b0 || ADR_O !== 32'h0 || req_done !== 3'b001 || req_err !== 3'b000 || req_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_done: got stb=%b adr=%h done=%b err=%b rdata=%h expected 0/0/001/000/deadbeef", STB_O, ADR_O, req_done, req_err, req_rdata);
    end
    @(negedge clk);
    checks++;
    if (req_done !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL read_after: got done=%b busy=%b expected 000/0", req_done, busy);
    end
  endtask

  task automatic test_single_write();
    req_valid = 3'b010; req_we = 3'b010;
    req_adr[63:32] = 32'h4000_0020; req_wdata[63:32] = 32'h1234_5678; req_sel[7:4] = 4'b0011;
    @(negedge clk);
    checks++;
    if (DAT_O !== 32'h1234_5678 || SEL_O !== 4'b0011 || WE_O !== 1'b1 || STB_O !== 1'b1 || ADR_O !== 32'h4000_0020 || grant_id !== 2'd1) begin
      errors++; $display("FAIL write_bus: got dat=%h sel=%b we=%b stb=%b adr=%h gid=%0d expected 12345678/0011/1/1/40000020/1", DAT_O, SEL_O, WE_O, STB_O, ADR_O, grant_id);
    end
    ACK_I = 1'b1; DAT_I = 32'hBAD0_BAD0;
    @(negedge clk);
    ACK_I = 1'b0; req_valid = 3'b000; req_we = 3'b000;
    checks++;
    if (STB_O !== 1'b0 || req_done !== 3'b010 || req_rdata !== 32'hDEAD_BEEF || DAT_O !== 32'h0) begin
      errors++; $display("FAIL write_done: got stb=%b done=%b rdata=%h dat=%h expected 0/010/deadbeef/0", STB_O, req_done, req_rdata, DAT_O);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int stb_cycles;
    req_valid = 3'b100; req_we = 3'b000; req_adr[95:64] = 32'h5000_0000;
    stb_cycles = 0;
    @(negedge clk);
    while (STB_O === 1'b1 && stb_cycles < 20) begin
      stb_cycles++;
      @(negedge clk);
    end
    req_valid = 3'b000;
    checks++;
    if (stb_cycles != TO) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected %0d", stb_cycles, TO);
    end
    checks++;
    if (req_done !== 3'b100 || req_err !== 3'b100 || CYC_O !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: got done=%b err=%b cyc=%b expected 100/100/0", req_done, req_err, CYC_O);
    end
    @(negedge clk);
    req_valid = 3'b001; req_we = 3'b001; req_wdata[31:0] = 32'h0BAD_CAFE; req_sel[3:0] = 4'b1111;
    @(negedge clk);
    checks++;
    if (STB_O !== 1'b1 || grant_id !== 2'd0 || DAT_O !== 32'h0BAD_CAFE) begin
      errors++; $display("FAIL timeout_next_grant: got stb=%b gid=%0d dat=%h expected 1/0/0badcafe", STB_O, grant_id, DAT_O);
    end
    ACK_I = 1'b1;
    @(negedge clk);
    ACK_I = 1'b0; req_valid = 3'b000; req_we = 3'b000;
    checks++;
    if (req_done !== 3'b001 || req_err !== 3'b000) begin
      errors++; $display("FAIL timeout_next_done: got done=%b err=%b expected 001/000", req_done, req_err);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_on_expiry();
    req_valid = 3'b001; req_we = 3'b000; req_adr[31:0] = 32'h3000_0044;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      if (c == TO - 1) begin
        ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
      end
    end
    @(negedge clk);
    ACK_I = 1'b0; DAT_I = 32'h0; req_valid = 3'b000;
    checks++;
    if (req_done !== 3'b001 || req_err !== 3'b000 || req_rdata !== 32'hCAFE_F00D || STB_O !== 1'b0) begin
      errors++; $display("FAIL ack_expiry: got done=%b err=%b rdata=%h stb=%b expected 001/000/cafef00d/0", req_done, req_err, req_rdata, STB_O);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_ack();
    ACK_I = 1'b1; DAT_I = 32'h5555_5555;
    repeat (2) @(negedge clk);
    checks++;
    if (STB_O !== 1'b0 || CYC_O !== 1'b0 || req_done !== 3'b000 || busy !== 1'b0 || req_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL idle_ack: got stb=%b cyc=%b done=%b busy=%b rdata=%h expected 0/0/000/0/cafef00d", STB_O, CYC_O, req_done, busy, req_rdata);
    end
    ACK_I = 1'b0; DAT_I = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b010; req_we = 3'b000;
    @(negedge clk);
    checks++;
    if (CYC_O !== 1'b1 || grant_id !== 2'd1) begin
      errors++; $display("FAIL rst_mid_pre: got cyc=%b gid=%0d expected 1/1", CYC_O, grant_id);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (CYC_O !== 1'b0 || STB_O !== 1'b0 || ADR_O !== 32'h0 || busy !== 1'b0 || grant_id !== 2'd0 || req_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_async: got cyc=%b stb=%b adr=%h busy=%b gid=%0d rdata=%h expected all 0", CYC_O, STB_O, ADR_O, busy, grant_id, req_rdata);
    end
    @(negedge clk);
    checks++;
    if (req_done !== 3'b000) begin
      errors++; $display("FAIL rst_mid_nodone: got %b expected 000", req_done);
    end
    req_valid = 3'b011;
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd0 || STB_O !== 1'b1) begin
      errors++; $display("FAIL rst_mid_first: got gid=%0d stb=%b expected 0/1", grant_id, STB_O);
    end
    ACK_I = 1'b1;
    @(negedge clk);
    ACK_I = 1'b0; req_valid = 3'b000;
    checks++;
    if (req_done !== 3'b001) begin
      errors++; $display("FAIL rst_mid_done: got %b expected 001", req_done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_single_write();
    test_timeout();
    test_ack_on_expiry();
    test_idle_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_11_wb_master_arbiter.md
# team_11_wb_master_arbiter

Shares the single Wishbone master port of the team_11 wrapper (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I) between NUM_REQ internal requesters. It performs one classic single-beat transfer at a time, selected round-robin. A per-transfer timeout guarantees forward progress when the upstream arbitrator never acknowledges. The block sits inside the team_11 top level, between the design's DMA/fetch engines and the wrapper's master outputs.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- TIMEOUT, 255: maximum STB_O-high cycles before abort, 1..65535; 0 disables the timeout.
- wb_clk_i  in  1: sole clock, rising edge.
- nrst  in  1: reset, asynchronous and active-low.
- req_valid  in  NUM_REQ: request per requester; held high until that requester's req_done.
- req_we  in  NUM_REQ: 1 = write, 0 = read.
- req_adr  in  32*NUM_REQ: byte address; slice i belongs to requester i.
- req_wdata  in  32*NUM_REQ: write data.
- req_sel  in  4*NUM_REQ: byte selects.
- req_done  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- req_err  out  NUM_REQ: one-cycle pulse coincident with req_done when the transfer timed out.
- req_rdata  out  32: read data, shared by all requesters.
- ADR_O, DAT_O  out  32 each: Wishbone master address and write data.
- SEL_O  out  4: byte selects.
- WE_O, STB_O, CYC_O  out  1 each: Wishbone master controls.
- DAT_I  in  32: Wishbone read data.
- ACK_I  in  1: Wishbone acknowledge.
- busy  out  1: high in BUS and RESP.
- grant_id  out  2: index of the current or most recent grant.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any req_valid is high, the winner is the first requester with req_valid set, scanning from last_grant+1 upward with wrap. At the edge, latch the winner's we/adr/wdata/sel into the master output registers, set CYC_O=STB_O=1, load last_grant and grant_id, clear the timeout counter, and go to BUS. If no req_valid is high, stay in IDLE.
- BUS:
  - ACK_I=1: capture DAT_I into req_rdata (reads only; writes leave req_rdata unchanged), drop CYC_O/STB_O, go to RESP.
  - ACK_I=0: increment the counter. If TIMEOUT≠0 and counter==TIMEOUT-1, abort instead: drop CYC_O/STB_O, flag error, go to RESP.
- RESP (exactly one cycle): req_done[grant_id]=1, and req_err[grant_id]=1 if aborted. The granted requester's req_valid is ignored in this cycle. Next state is IDLE.
- While CYC_O=0, ADR_O/DAT_O/SEL_O/WE_O are driven to 0.
- ACK_I is ignored outside BUS.
- Requester inputs are sampled only at grant. Changes during BUS are ignored. Dropping req_valid mid-transfer does not cancel the transfer.
- Counter width is max(1, clog2(TIMEOUT+1)) bits.

## Timing
- Reset values: state=IDLE, all Wishbone outputs 0, req_done=0, req_err=0, req_rdata=0, busy=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first).
- All outputs are registered. No combinational path from any input to any output.
- Grant latency: req_valid high before edge E0 in IDLE gives CYC_O/STB_O and the address/data outputs valid from E0.
- Completion: ACK_I sampled high at edge E1 gives STB_O/CYC_O low after E1, req_done high E1–E2, and req_rdata valid from E1, held until the next read ACK.
- Zero-wait slave: STB_O is high exactly 1 cycle. Back-to-back transfers have a minimum period of 3 cycles (BUS, RESP, IDLE).
- Timeout: STB_O is high exactly TIMEOUT cycles and never longer.
- ACK_I high on the same edge the counter would expire: ACK wins, no error.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). No req_done is issued. The requester re-issues after reset.
- Simultaneous requests: strict rotation. With all NUM_REQ requesters continuously asserting, each is granted once per NUM_REQ transfers.

## Test plan
- Single read, requester 0, req_adr=0x3000_0010, slave ACKs 2 cycles after STB_O with DAT_I=0xDEAD_BEEF -> ADR_O=0x3000_0010 and WE_O=0 for 3 cycles; req_done[0] one pulse; req_rdata=0xDEAD_BEEF; req_err=0.
- Single write, requester 1, wdata=0x1234_5678, sel=4'b0011, zero-wait ACK -> DAT_O=0x1234_5678, SEL_O=0011, WE_O=1, STB_O high 1 cycle; req_rdata unchanged.
- NUM_REQ=3, all requesters hold req_valid for 6 transfers -> grant_id sequence 0,1,2,0,1,2; each req_done pulses twice.
- TIMEOUT=8, ACK_I held low -> STB_O high exactly 8 cycles; req_done[g] and req_err[g] pulse together; next request granted normally.
- ACK_I asserted exactly on the expiry cycle -> req_err=0, data captured. Separately, ACK_I pulsed while IDLE -> no outputs change.
- nrst pulled low while in BUS -> CYC_O/STB_O=0 within the same cycle, no req_done. After release, requester 0 wins first.
